// File: rtl/sr2_latch.sv
// Clocked SR cell array with complementary outputs and a selectable S=R=1 policy.
// Define SR2_LATCH_SYNC_EN to put a 2-flop synchronizer on s and r.
module sr2_latch #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned SR11_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] illegal
);

  typedef enum logic [1:0] {
    P_NOR  = 2'd0,
    P_SET  = 2'd1,
    P_RST  = 2'd2,
    P_HOLD = 2'd3
  } pol_e;

  // Out-of-range modes fall back to NOR behaviour.
  localparam pol_e POL = (SR11_MODE == 1) ? P_SET  :
                         (SR11_MODE == 2) ? P_RST  :
                         (SR11_MODE == 3) ? P_HOLD : P_NOR;

  logic [WIDTH-1:0] s_e;
  logic [WIDTH-1:0] r_e;

`ifdef SR2_LATCH_SYNC_EN
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] r1_q, r2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
    end else begin
      s1_q <= s;
      s2_q <= s1_q;
      r1_q <= r;
      r2_q <= r1_q;
    end
  end

  assign s_e = s2_q;
  assign r_e = r2_q;
`else
  assign s_e = s;
  assign r_e = r;
`endif

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic [WIDTH-1:0] ill_q, ill_d;

  logic [WIDTH-1:0] set_only;
  logic [WIDTH-1:0] rst_only;
  logic [WIDTH-1:0] both;

  assign set_only = s_e & ~r_e;
  assign rst_only = ~s_e & r_e;
  assign both     = s_e & r_e;

  // Hold drives qb from ~q, so a NOR-mode 0/0 state resolves to reset.
  always_comb begin
    q_d   = q_q;
    qb_d  = ~q_q;
    ill_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      unique case (1'b1)
        set_only[i]: begin
          q_d[i]  = 1'b1;
          qb_d[i] = 1'b0;
        end
        rst_only[i]: begin
          q_d[i]  = 1'b0;
          qb_d[i] = 1'b1;
        end
        both[i]: begin
          ill_d[i] = 1'b1;
          unique case (POL)
            P_SET: begin
              q_d[i]  = 1'b1;
              qb_d[i] = 1'b0;
            end
            P_RST: begin
              q_d[i]  = 1'b0;
              qb_d[i] = 1'b1;
            end
            P_HOLD: begin
              q_d[i]  = q_q[i];
              qb_d[i] = ~q_q[i];
            end
            default: begin
              q_d[i]  = 1'b0;
              qb_d[i] = 1'b0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q   <= '0;
      qb_q  <= '1;
      ill_q <= '0;
    end else begin
      q_q   <= q_d;
      qb_q  <= qb_d;
      ill_q <= ill_d;
    end
  end

  assign q       = q_q;
  assign qb      = qb_q;
  assign illegal = ill_q;

endmodule

// File: tb/tb_sr2_latch.sv
// Directed bench for sr2_latch: all S=R=1 policies, multi-bit cells, reset.
// Expected latency follows SR2_LATCH_SYNC_EN.
module tb_sr2_latch;

`ifdef SR2_LATCH_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic s1, r1;
  logic [3:0] s4, r4;

  logic q0, qb0, il0;
  logic q1, qb1, il1;
  logic q2, qb2, il2;
  logic q3, qb3, il3;
  logic q5, qb5, il5;
  logic [3:0] q4, qb4, il4;

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  sr2_latch #(.WIDTH(1), .SR11_MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q0), .qb(qb0), .illegal(il0));
  sr2_latch #(.WIDTH(1), .SR11_MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q1), .qb(qb1), .illegal(il1));
  sr2_latch #(.WIDTH(1), .SR11_MODE(2)) u_m2 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q2), .qb(qb2), .illegal(il2));
  sr2_latch #(.WIDTH(1), .SR11_MODE(3)) u_m3 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q3), .qb(qb3), .illegal(il3));
  sr2_latch #(.WIDTH(1), .SR11_MODE(5)) u_m5 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q5), .qb(qb5), .illegal(il5));
  sr2_latch #(.WIDTH(4), .SR11_MODE(0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .s(s4), .r(r4),
    .q(q4), .qb(qb4), .illegal(il4));

  task automatic chk(input string tag,
                     input logic [11:0] got,
                     input logic [11:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sequence for the mode-0 illegal walk, {s,r} and {q,qb,illegal}.
  logic [1:0] seq_sr [10];
  logic [2:0] seq_ex [10];

  // Policy walk: (1,0), (1,1), (0,0) per mode.
  logic [1:0] pol_sr [3];
  logic [2:0] pol_m0 [3];
  logic [2:0] pol_m1 [3];
  logic [2:0] pol_m2 [3];
  logic [2:0] pol_m3 [3];

  initial begin
    seq_sr = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11,
               2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    seq_ex = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b001,
               3'b010, 3'b010, 3'b100, 3'b001, 3'b100};
    pol_sr = '{2'b10, 2'b11, 2'b00};
    pol_m0 = '{3'b100, 3'b001, 3'b010};
    pol_m1 = '{3'b100, 3'b101, 3'b100};
    pol_m2 = '{3'b100, 3'b011, 3'b010};
    pol_m3 = '{3'b100, 3'b101, 3'b100};

    rst_n = 1'b0;
    s1 = 1'b1; r1 = 1'b0;
    s4 = 4'b1111; r4 = 4'b0000;
    cyc(2);
    chk("rst_m0", {9'd0, q0, qb0, il0}, 12'b010);
    chk("rst_m1", {9'd0, q1, qb1, il1}, 12'b010);
    chk("rst_w4", {q4, qb4, il4}, {4'h0, 4'hf, 4'h0});

    rst_n = 1'b1;
    s4 = 4'b0000;
    cyc(LAT);
    chk("set_m0", {9'd0, q0, qb0, il0}, 12'b100);
    chk("set_m3", {9'd0, q3, qb3, il3}, 12'b100);

    s1 = 1'b0; r1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk($sformatf("hold1_%0d", k), {9'd0, q0, qb0, il0}, 12'b100);
    end

    r1 = 1'b1;
    cyc(LAT);
    chk("reset_m0", {9'd0, q0, qb0, il0}, 12'b010);
    r1 = 1'b0;
    cyc(10);
    chk("hold0_m0", {9'd0, q0, qb0, il0}, 12'b010);

    for (int k = 0; k < 10; k++) begin
      {s1, r1} = seq_sr[k];
      cyc(10);
      chk($sformatf("seq_m0_%0d", k),
          {9'd0, q0, qb0, il0}, {9'd0, seq_ex[k]});
      chk($sformatf("seq_m5_%0d", k),
          {9'd0, q5, qb5, il5}, {9'd0, seq_ex[k]});
    end

    for (int k = 0; k < 3; k++) begin
      {s1, r1} = pol_sr[k];
      cyc(10);
      chk($sformatf("pol_m0_%0d", k),
          {9'd0, q0, qb0, il0}, {9'd0, pol_m0[k]});
      chk($sformatf("pol_m1_%0d", k),
          {9'd0, q1, qb1, il1}, {9'd0, pol_m1[k]});
      chk($sformatf("pol_m2_%0d", k),
          {9'd0, q2, qb2, il2}, {9'd0, pol_m2[k]});
      chk($sformatf("pol_m3_%0d", k),
          {9'd0, q3, qb3, il3}, {9'd0, pol_m3[k]});
    end

    // Bit3 holds reset, bit2 set, bit1 reset, bit0 NOR-illegal.
    s4 = 4'b0101; r4 = 4'b0011;
    cyc(LAT);
    chk("w4_mix", {q4, qb4, il4}, {4'b0100, 4'b1010, 4'b0001});
    rst_n = 1'b0;
    cyc(1);
    chk("w4_rst", {q4, qb4, il4}, {4'h0, 4'hf, 4'h0});
    rst_n = 1'b1;
    s4 = 4'b0000; r4 = 4'b0000;
    cyc(LAT);
    chk("w4_rel", {q4, qb4, il4}, {4'h0, 4'hf, 4'h0});

    // Latency: q must rise exactly LAT edges after the sampling edge.
    s1 = 1'b0; r1 = 1'b1;
    cyc(5);
    r1 = 1'b0; s1 = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      cyc(1);
      chk($sformatf("lat_%0d", k),
          {11'd0, q0}, {11'd0, (k == LAT - 1)});
    end

    // A request overtaken by reset must not reappear afterwards.
    s1 = 1'b0; r1 = 1'b1;
    cyc(5);
    chk("pend_pre", {9'd0, q0, qb0, il0}, 12'b010);
    r1 = 1'b0; s1 = 1'b1;
    cyc(1);
    s1 = 1'b0;
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk($sformatf("pend_%0d", k), {9'd0, q0, qb0, il0}, 12'b010);
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
